// File: rtl/data_register_pkg.sv
// data_register_pkg: project-wide datapath constants shared by the storage registers
package data_register_pkg;
  localparam int DATAWIDTH_DEFAULT = 8;
endpackage

// File: rtl/data_register_reg_bit_cell.sv
// reg_bit_cell: one storage bit with load enable, hold mux and async preset/clear
module reg_bit_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enb_i,
  input  logic d_i,
  output logic q_o
);
  logic bit_d, bit_q;
  // take new data when enabled, otherwise recirculate the stored bit
  always_comb bit_d = enb_i ? d_i : bit_q;
  // storage flop; reset forces the per-bit reset value without waiting for clk
  always_ff @(posedge clk or posedge rst)
    if (rst) bit_q <= RESET_BIT;
    else     bit_q <= bit_d;
  assign q_o = bit_q;
endmodule

// File: rtl/data_register.sv
// data_register: parallel-load register built from independent bit cells
module data_register
  import data_register_pkg::*;
#(
  parameter int                  DATASIZE = DATAWIDTH_DEFAULT,
  parameter logic [DATASIZE-1:0] RESETVAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic [DATASIZE-1:0] data_in,
  output logic [DATASIZE-1:0] data_out
);
  for (genvar i = 0; i < DATASIZE; i++) begin : g_bit
    reg_bit_cell #(.RESET_BIT(RESETVAL[i])) u_cell (
      .clk  (clk),
      .rst  (rst),
      .enb_i(enb),
      .d_i  (data_in[i]),
      .q_o  (data_out[i])
    );
  end
endmodule

// File: tb/tb_data_register.sv
// tb_data_register: vector table plus hand sequences against a 4-bit and a 16-bit register
module tb_data_register;
  logic clk = 1'b0;
  logic rst4, enb4, rst16, enb16;
  logic [3:0] din4, dout4;
  logic [15:0] din16, dout16;
  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    bit          w;
    bit          r;
    bit          e;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  data_register #(.DATASIZE(4)) u_n (
    .clk(clk), .rst(rst4), .enb(enb4), .data_in(din4), .data_out(dout4)
  );

  data_register #(.DATASIZE(16), .RESETVAL(16'h00FF)) u_w (
    .clk(clk), .rst(rst16), .enb(enb16), .data_in(din16), .data_out(dout16)
  );

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string nm, input bit w);
    logic [15:0] act, exp;
    act = w ? dout16 : {12'h0, dout4};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", nm, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm, act, exp);
      end
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    if (v.w) begin
      rst16 = v.r; enb16 = v.e; din16 = v.d; enb4 = 1'b0;
    end else begin
      rst4 = v.r; enb4 = v.e; din4 = v.d[3:0]; enb16 = 1'b0;
    end
    push(v.exp);
    @(posedge clk);
    #1 check($sformatf("vec%0d", idx), v.w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{w:0, r:0, e:1, d:16'hA,    exp:16'hA};
    vecs[1]  = '{w:0, r:0, e:1, d:16'h5,    exp:16'h5};
    vecs[2]  = '{w:0, r:0, e:0, d:16'h0,    exp:16'h5};
    vecs[3]  = '{w:0, r:0, e:0, d:16'hF,    exp:16'h5};
    vecs[4]  = '{w:0, r:0, e:0, d:16'h3,    exp:16'h5};
    vecs[5]  = '{w:0, r:0, e:1, d:16'hA,    exp:16'hA};
    vecs[6]  = '{w:1, r:1, e:1, d:16'h1234, exp:16'h00FF};
    vecs[7]  = '{w:1, r:0, e:1, d:16'hAAAA, exp:16'hAAAA};
    vecs[8]  = '{w:1, r:0, e:1, d:16'h5555, exp:16'h5555};
    vecs[9]  = '{w:1, r:0, e:0, d:16'hFFFF, exp:16'h5555};
    vecs[10] = '{w:1, r:1, e:0, d:16'h0000, exp:16'h00FF};
    vecs[11] = '{w:1, r:0, e:1, d:16'h0F0F, exp:16'h0F0F};

    rst4 = 1'b1; enb4 = 1'b0; din4 = 4'h0;
    rst16 = 1'b1; enb16 = 1'b0; din16 = 16'h0;
    push(16'h0);
    #1 check("reset4", 1'b0);
    push(16'h00FF);
    check("reset16", 1'b1);

    for (int i = 0; i < 12; i++) apply(vecs[i], i);

    @(negedge clk);
    enb4 = 1'b1; din4 = 4'h0;
    push(16'hA);
    #1 check("nocomb_enb", 1'b0);
    enb4 = 1'b0; din4 = 4'hF;
    push(16'hA);
    #1 check("nocomb_din", 1'b0);

    @(negedge clk);
    rst4 = 1'b1; enb4 = 1'b1; din4 = 4'hF;
    push(16'h0);
    #1 check("async_rst", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      push(16'h0);
      #1 check($sformatf("rst_hold%0d", i), 1'b0);
    end

    @(negedge clk);
    rst4 = 1'b0; enb4 = 1'b1; din4 = 4'hC;
    push(16'hC);
    @(posedge clk);
    #1 check("rel_load", 1'b0);
    @(negedge clk);
    enb4 = 1'b0; din4 = 4'h6;
    push(16'hC);
    @(posedge clk);
    #1 check("rel_hold", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
